rs_pool: RTL and testbench
==========================

Name: rs_pool

Overview:
- Parametrised reservation-station pool for one functional-unit class (ALU, MUL/DIV or LSU); one instance per class.
- Holds up to DEPTH dispatched instructions and captures missing source operands from NUM_CDB common-data-bus channels, matched by ROB index.
- Issues the oldest entry whose operands are both ready to its execute unit over a valid/ready handshake.
- Sits between dispatch and the execute units; the opaque control payload (pc, imm, aluop, mux selects, rd_addr, regf_we) passes through unchanged.

Parameters:
- DEPTH, 4: number of entries (2..16).
- ROB_IDX_WIDTH, 5: ROB tag width.
- DATA_WIDTH, 32: operand width.
- NUM_CDB, 2: number of broadcast channels.
- PAYLOAD_WIDTH, 96: opaque control payload width.
- CNT_WIDTH, $clog2(DEPTH+1): occupancy count width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- flush  in  1  discard all entries (mispredict/exception).
- alloc_valid  in  1  dispatch presents an instruction.
- alloc_ready  out  1  pool accepts an allocation this cycle.
- alloc_rd_rob_idx  in  ROB_IDX_WIDTH  destination ROB tag.
- alloc_rs1_ready, alloc_rs2_ready  in  1 each  operand already available.
- alloc_rs1_data, alloc_rs2_data  in  DATA_WIDTH each  operand value when ready.
- alloc_rs1_rob_idx, alloc_rs2_rob_idx  in  ROB_IDX_WIDTH each  producer tag when not ready.
- alloc_payload  in  PAYLOAD_WIDTH  control payload.
- cdb_valid  in  NUM_CDB  per-channel broadcast valid.
- cdb_rob_idx  in  NUM_CDB*ROB_IDX_WIDTH  packed tags; channel k at [k*W +: W].
- cdb_data  in  NUM_CDB*DATA_WIDTH  packed results.
- issue_valid  out  1  an entry is issuing.
- issue_ready  in  1  execute unit accepts.
- issue_rs1_data, issue_rs2_data  out  DATA_WIDTH each  operands.
- issue_rd_rob_idx  out  ROB_IDX_WIDTH  destination tag.
- issue_payload  out  PAYLOAD_WIDTH  control payload.
- count  out  CNT_WIDTH  occupied entries.

Behaviour:
- Reset (async, rst=1):
  - All entry valid bits and age state clear.
  - Outputs: count=0, alloc_ready=1, issue_valid=0.
  - issue_* data, tag and payload outputs = 0.
- Entry state: valid, rs1/rs2 ready, data and tag, rd tag, payload, and age rank relative to other entries.
- Allocation:
  - alloc_ready = (count < DEPTH) && !flush.
  - On alloc_valid && alloc_ready, the lowest-index free entry is written at the edge and becomes the youngest.
  - A freed slot cannot be reallocated in the same cycle it issues.
- Wakeup:
  - Each cycle, every valid entry with an operand not ready compares that operand's tag against all valid CDB channels.
  - On a match, the data is captured and ready set at the edge.
  - rs1 and rs2 may wake in the same cycle, from the same or different channels.
  - If several channels match one operand, the lowest channel index wins.
- Allocation bypass: an operand allocated not-ready whose tag matches a CDB channel in the allocation cycle is stored ready with the CDB data.
- Issue select (combinational from registered state only):
  - Eligible = valid && rs1_ready && rs2_ready.
  - issue_valid = any entry eligible; issue_* reflect the oldest eligible entry; zeros when none.
  - Fire = issue_valid && issue_ready; the selected entry clears at the edge.
  - While issue_ready=0, the selection may change only to an older newly eligible entry; entries are never lost.
- Latency:
  - Allocation with both operands ready: issue_valid can be 1 the cycle after allocation.
  - CDB wakeup: eligible the cycle after the broadcast.
  - No same-cycle CDB-to-issue bypass.
- count updates at the edge by +alloc_fire −issue_fire; simultaneous alloc and issue leaves count unchanged.
- Flush:
  - At the edge, all entries invalidate and count becomes 0.
  - Flush beats alloc and issue in the same cycle; alloc_ready is already 0.
  - issue_valid stays combinational and may still be 1 during the flush cycle; the consumer gates it with flush.
- Age ordering:
  - Strictly by allocation order, independent of slot index.
  - Holds across slot reuse and wrap-around; no two valid entries share an age.
- Full: alloc_ready=0 until an issue frees a slot; alloc_ready rises the cycle after the fire.
- Empty: issue_valid=0 and outputs are zero; CDB activity is ignored.

Test Plan:
- Reset, then allocate tag 3 with rs1=0x10 and rs2=0x20 both ready, issue_ready=1 → next cycle issue_valid=1, rs1=0x10, rs2=0x20, rd tag=3; cycle after that count=0.
- Allocate tag 5 waiting on rs1 tag 7 and rs2 tag 9; same cycle cdb0 = (7, 0xAA) and cdb1 = (9, 0xBB) → both operands ready; next cycle issue of 0xAA/0xBB (both-operand wakeup, both channels).
- Fill DEPTH=4 with tags 1,2,3,4, all ready, issue_ready=0 → alloc_ready=0 and count=4; raise issue_ready → tags issue in order 1,2,3,4, one per cycle, and alloc_ready=1 after the first fire.
- Allocate A (tag 1, waiting) then B (tag 2, ready); later broadcast A's producer → B issues first; A issues once ready, even when A's slot index is higher after slot reuse.
- Allocation bypass: allocate with rs2 waiting on tag 12 while cdb1 = (12, 0x1234) in the same cycle → stored entry issues next cycle with rs2=0x1234.
- With 3 entries valid, assert flush together with alloc_valid → next cycle count=0 and issue_valid=0, and the allocation is dropped; assert rst mid-stream → outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rs_pool.sv
// rs_pool: reservation-station pool for one functional-unit class.
//   Holds up to DEPTH dispatched instructions and captures missing source
//   operands from NUM_CDB broadcast channels (matched by ROB tag). Issues the
//   oldest entry whose operands are both ready over a valid/ready handshake.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   flush               drop every entry (mispredict/exception)
//   alloc_*             dispatch side: valid/ready plus operand state, tags, payload
//   cdb_valid/rob_idx/data  packed broadcast channels, channel k at [k*W +: W]
//   issue_*             execute side: valid/ready, operands, rd tag, payload
//   count               number of occupied entries
module rs_pool #(
  parameter int DEPTH         = 4,
  parameter int ROB_IDX_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_CDB       = 2,
  parameter int PAYLOAD_WIDTH = 96,
  parameter int CNT_WIDTH     = $clog2(DEPTH + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             alloc_valid,
  output logic                             alloc_ready,
  input  logic [ROB_IDX_WIDTH-1:0]         alloc_rd_rob_idx,
  input  logic                             alloc_rs1_ready,
  input  logic                             alloc_rs2_ready,
  input  logic [DATA_WIDTH-1:0]            alloc_rs1_data,
  input  logic [DATA_WIDTH-1:0]            alloc_rs2_data,
  input  logic [ROB_IDX_WIDTH-1:0]         alloc_rs1_rob_idx,
  input  logic [ROB_IDX_WIDTH-1:0]         alloc_rs2_rob_idx,
  input  logic [PAYLOAD_WIDTH-1:0]         alloc_payload,
  input  logic [NUM_CDB-1:0]               cdb_valid,
  input  logic [NUM_CDB*ROB_IDX_WIDTH-1:0] cdb_rob_idx,
  input  logic [NUM_CDB*DATA_WIDTH-1:0]    cdb_data,
  output logic                             issue_valid,
  input  logic                             issue_ready,
  output logic [DATA_WIDTH-1:0]            issue_rs1_data,
  output logic [DATA_WIDTH-1:0]            issue_rs2_data,
  output logic [ROB_IDX_WIDTH-1:0]         issue_rd_rob_idx,
  output logic [PAYLOAD_WIDTH-1:0]         issue_payload,
  output logic [CNT_WIDTH-1:0]             count
);

  localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);

  logic [DEPTH-1:0]         valid_q, valid_d;
  logic [DEPTH-1:0]         rs1_rdy_q, rs1_rdy_d, rs2_rdy_q, rs2_rdy_d;
  logic [DATA_WIDTH-1:0]    rs1_data_q [DEPTH];
  logic [DATA_WIDTH-1:0]    rs1_data_d [DEPTH];
  logic [DATA_WIDTH-1:0]    rs2_data_q [DEPTH];
  logic [DATA_WIDTH-1:0]    rs2_data_d [DEPTH];
  logic [ROB_IDX_WIDTH-1:0] rs1_tag_q  [DEPTH];
  logic [ROB_IDX_WIDTH-1:0] rs1_tag_d  [DEPTH];
  logic [ROB_IDX_WIDTH-1:0] rs2_tag_q  [DEPTH];
  logic [ROB_IDX_WIDTH-1:0] rs2_tag_d  [DEPTH];
  logic [ROB_IDX_WIDTH-1:0] rd_tag_q   [DEPTH];
  logic [ROB_IDX_WIDTH-1:0] rd_tag_d   [DEPTH];
  logic [PAYLOAD_WIDTH-1:0] payload_q  [DEPTH];
  logic [PAYLOAD_WIDTH-1:0] payload_d  [DEPTH];
  // older_q[i][j] = 1 when entry j was allocated before entry i. A newly
  // allocated slot clears its column everywhere, so stale bits left by
  // departed entries never survive a reuse of that slot.
  logic [DEPTH-1:0]         older_q    [DEPTH];
  logic [DEPTH-1:0]         older_d    [DEPTH];
  logic [CNT_WIDTH-1:0]     count_q, count_d;

  logic [DEPTH-1:0]      eligible;
  logic                  sel_found;
  logic [SW-1:0]         sel_idx;
  logic [SW-1:0]         alloc_idx;
  logic                  alloc_fire, issue_fire;
  logic                  a_rs1_rdy, a_rs2_rdy;
  logic [DATA_WIDTH-1:0] a_rs1_data, a_rs2_data;

  // Oldest-ready select, from registered state only.
  always_comb begin
    eligible  = valid_q & rs1_rdy_q & rs2_rdy_q;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!sel_found && eligible[i] && ((older_q[i] & eligible) == '0)) begin
        sel_found = 1'b1;
        sel_idx   = SW'(i);
      end
    end
  end

  assign issue_valid      = sel_found;
  assign issue_rs1_data   = sel_found ? rs1_data_q[sel_idx] : '0;
  assign issue_rs2_data   = sel_found ? rs2_data_q[sel_idx] : '0;
  assign issue_rd_rob_idx = sel_found ? rd_tag_q[sel_idx]   : '0;
  assign issue_payload    = sel_found ? payload_q[sel_idx]  : '0;
  assign count            = count_q;

  assign alloc_ready = (count_q < DEPTH_C) && !flush;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign issue_fire  = issue_valid && issue_ready && !flush;

  // Lowest free slot, judged on registered valid bits so a slot freed by
  // this cycle's issue is not handed out again until next cycle.
  always_comb begin
    alloc_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) alloc_idx = SW'(i);
    end
  end

  // Allocation bypass: descending scan so the lowest matching channel wins.
  always_comb begin
    a_rs1_rdy  = alloc_rs1_ready;
    a_rs1_data = alloc_rs1_data;
    a_rs2_rdy  = alloc_rs2_ready;
    a_rs2_data = alloc_rs2_data;
    for (int k = NUM_CDB - 1; k >= 0; k--) begin
      if (!alloc_rs1_ready && cdb_valid[k] &&
          cdb_rob_idx[k*ROB_IDX_WIDTH +: ROB_IDX_WIDTH] == alloc_rs1_rob_idx) begin
        a_rs1_rdy  = 1'b1;
        a_rs1_data = cdb_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
      if (!alloc_rs2_ready && cdb_valid[k] &&
          cdb_rob_idx[k*ROB_IDX_WIDTH +: ROB_IDX_WIDTH] == alloc_rs2_rob_idx) begin
        a_rs2_rdy  = 1'b1;
        a_rs2_data = cdb_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    valid_d    = valid_q;
    rs1_rdy_d  = rs1_rdy_q;
    rs2_rdy_d  = rs2_rdy_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    rs1_tag_d  = rs1_tag_q;
    rs2_tag_d  = rs2_tag_q;
    rd_tag_d   = rd_tag_q;
    payload_d  = payload_q;
    older_d    = older_q;
    count_d    = count_q + CNT_WIDTH'(alloc_fire) - CNT_WIDTH'(issue_fire);

    // Wakeup of waiting operands in resident entries.
    for (int i = 0; i < DEPTH; i++) begin
      for (int k = NUM_CDB - 1; k >= 0; k--) begin
        if (valid_q[i] && !rs1_rdy_q[i] && cdb_valid[k] &&
            cdb_rob_idx[k*ROB_IDX_WIDTH +: ROB_IDX_WIDTH] == rs1_tag_q[i]) begin
          rs1_rdy_d[i]  = 1'b1;
          rs1_data_d[i] = cdb_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
        if (valid_q[i] && !rs2_rdy_q[i] && cdb_valid[k] &&
            cdb_rob_idx[k*ROB_IDX_WIDTH +: ROB_IDX_WIDTH] == rs2_tag_q[i]) begin
          rs2_rdy_d[i]  = 1'b1;
          rs2_data_d[i] = cdb_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end

    if (issue_fire) valid_d[sel_idx] = 1'b0;

    if (alloc_fire) begin
      valid_d[alloc_idx]    = 1'b1;
      rs1_rdy_d[alloc_idx]  = a_rs1_rdy;
      rs2_rdy_d[alloc_idx]  = a_rs2_rdy;
      rs1_data_d[alloc_idx] = a_rs1_data;
      rs2_data_d[alloc_idx] = a_rs2_data;
      rs1_tag_d[alloc_idx]  = alloc_rs1_rob_idx;
      rs2_tag_d[alloc_idx]  = alloc_rs2_rob_idx;
      rd_tag_d[alloc_idx]   = alloc_rd_rob_idx;
      payload_d[alloc_idx]  = alloc_payload;
      // Everyone currently resident is older; the new entry is older than no one.
      older_d[alloc_idx]    = valid_q;
      for (int i = 0; i < DEPTH; i++) older_d[i][alloc_idx] = 1'b0;
    end

    if (flush) begin
      valid_d = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= '0;
      rs1_rdy_q <= '0;
      rs2_rdy_q <= '0;
      count_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rs1_data_q[i] <= '0;
        rs2_data_q[i] <= '0;
        rs1_tag_q[i]  <= '0;
        rs2_tag_q[i]  <= '0;
        rd_tag_q[i]   <= '0;
        payload_q[i]  <= '0;
        older_q[i]    <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      rs1_rdy_q  <= rs1_rdy_d;
      rs2_rdy_q  <= rs2_rdy_d;
      count_q    <= count_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      rs1_tag_q  <= rs1_tag_d;
      rs2_tag_q  <= rs2_tag_d;
      rd_tag_q   <= rd_tag_d;
      payload_q  <= payload_d;
      older_q    <= older_d;
    end
  end

endmodule

// File: tb/tb_rs_pool.sv
// Testbench for rs_pool: directed sequences, a vector table for single-entry
// allocation/bypass cases, and randomized traffic checked every cycle against
// an age-ordered queue model of the pool.
module tb_rs_pool;
  localparam int DEPTH = 4;
  localparam int RW    = 5;
  localparam int DW    = 32;
  localparam int NC    = 2;
  localparam int PW    = 96;
  localparam int CW    = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           flush = 1'b0;
  logic           alloc_valid = 1'b0;
  logic           alloc_ready;
  logic [RW-1:0]  alloc_rd_rob_idx = '0;
  logic           alloc_rs1_ready = 1'b0, alloc_rs2_ready = 1'b0;
  logic [DW-1:0]  alloc_rs1_data = '0, alloc_rs2_data = '0;
  logic [RW-1:0]  alloc_rs1_rob_idx = '0, alloc_rs2_rob_idx = '0;
  logic [PW-1:0]  alloc_payload = '0;
  logic [NC-1:0]  cdb_valid = '0;
  logic [NC*RW-1:0] cdb_rob_idx = '0;
  logic [NC*DW-1:0] cdb_data = '0;
  logic           issue_valid;
  logic           issue_ready = 1'b0;
  logic [DW-1:0]  issue_rs1_data, issue_rs2_data;
  logic [RW-1:0]  issue_rd_rob_idx;
  logic [PW-1:0]  issue_payload;
  logic [CW-1:0]  count;

  always #5 clk = ~clk;

  rs_pool #(.DEPTH(DEPTH), .ROB_IDX_WIDTH(RW), .DATA_WIDTH(DW), .NUM_CDB(NC),
            .PAYLOAD_WIDTH(PW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_rd_rob_idx(alloc_rd_rob_idx),
    .alloc_rs1_ready(alloc_rs1_ready), .alloc_rs2_ready(alloc_rs2_ready),
    .alloc_rs1_data(alloc_rs1_data), .alloc_rs2_data(alloc_rs2_data),
    .alloc_rs1_rob_idx(alloc_rs1_rob_idx), .alloc_rs2_rob_idx(alloc_rs2_rob_idx),
    .alloc_payload(alloc_payload),
    .cdb_valid(cdb_valid), .cdb_rob_idx(cdb_rob_idx), .cdb_data(cdb_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rs1_data(issue_rs1_data), .issue_rs2_data(issue_rs2_data),
    .issue_rd_rob_idx(issue_rd_rob_idx), .issue_payload(issue_payload),
    .count(count)
  );

  // Reference model: resident instructions kept in allocation order.
  typedef struct {
    logic [RW-1:0] tag;
    logic          r1;
    logic [DW-1:0] d1;
    logic [RW-1:0] t1;
    logic          r2;
    logic [DW-1:0] d2;
    logic [RW-1:0] t2;
    logic [PW-1:0] pl;
  } m_ent_t;
  m_ent_t q[$];

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Capture broadcast results; the first matching channel in index order wins.
  function automatic void wake(inout m_ent_t e);
    for (int k = 0; k < NC; k++) begin
      if (cdb_valid[k]) begin
        if (!e.r1 && cdb_rob_idx[k*RW +: RW] == e.t1) begin
          e.r1 = 1'b1; e.d1 = cdb_data[k*DW +: DW];
        end
        if (!e.r2 && cdb_rob_idx[k*RW +: RW] == e.t2) begin
          e.r2 = 1'b1; e.d2 = cdb_data[k*DW +: DW];
        end
      end
    end
  endfunction

  function automatic int oldest_ready();
    for (int i = 0; i < q.size(); i++)
      if (q[i].r1 && q[i].r2) return i;
    return -1;
  endfunction

  // One clock: compare DUT outputs to the model with current inputs, then
  // advance the model and the DUT across the rising edge.
  task automatic cyc();
    int s;
    m_ent_t e;
    logic fa, fi;
    #1;
    s = oldest_ready();
    chk("alloc_ready", 128'(alloc_ready), 128'((q.size() < DEPTH) && !flush));
    chk("count", 128'(count), 128'(q.size()));
    chk("issue_valid", 128'(issue_valid), 128'(s >= 0));
    if (s >= 0) begin
      chk("issue_rs1", 128'(issue_rs1_data), 128'(q[s].d1));
      chk("issue_rs2", 128'(issue_rs2_data), 128'(q[s].d2));
      chk("issue_rd", 128'(issue_rd_rob_idx), 128'(q[s].tag));
      chk("issue_payload", 128'(issue_payload), 128'(q[s].pl));
    end else begin
      chk("idle_outputs", {issue_payload, issue_rd_rob_idx, issue_rs1_data != '0, issue_rs2_data != '0}, '0);
    end
    fa = alloc_valid && (q.size() < DEPTH) && !flush;
    fi = (s >= 0) && issue_ready && !flush;
    if (flush) q.delete();
    else begin
      if (fi) q.delete(s);
      for (int i = 0; i < q.size(); i++) begin
        e = q[i]; wake(e); q[i] = e;
      end
      if (fa) begin
        e.tag = alloc_rd_rob_idx;
        e.r1 = alloc_rs1_ready; e.d1 = alloc_rs1_data; e.t1 = alloc_rs1_rob_idx;
        e.r2 = alloc_rs2_ready; e.d2 = alloc_rs2_data; e.t2 = alloc_rs2_rob_idx;
        e.pl = alloc_payload;
        wake(e);
        q.push_back(e);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic alloc_in(input int tag, input int r1, input int d1, input int t1,
                          input int r2, input int d2, input int t2);
    alloc_valid       = 1'b1;
    alloc_rd_rob_idx  = RW'(tag);
    alloc_rs1_ready   = r1 != 0;
    alloc_rs1_data    = DW'(d1);
    alloc_rs1_rob_idx = RW'(t1);
    alloc_rs2_ready   = r2 != 0;
    alloc_rs2_data    = DW'(d2);
    alloc_rs2_rob_idx = RW'(t2);
    alloc_payload     = {$urandom, $urandom, $urandom};
  endtask

  task automatic idle();
    alloc_valid = 1'b0;
    cdb_valid   = '0;
  endtask

  task automatic set_cdb(input logic [1:0] v, input int t0, input int dd0,
                         input int t1, input int dd1);
    cdb_valid   = v;
    cdb_rob_idx = {RW'(t1), RW'(t0)};
    cdb_data    = {DW'(dd1), DW'(dd0)};
  endtask

  typedef struct {
    int r1; int d1; int t1;
    int r2; int d2; int t2;
    logic [1:0] cv; int ct0; int cd0; int ct1; int cd1;
    int ev; int e1; int e2;
  } tv_t;
  tv_t tv[8];

  initial begin
    tv[0] = '{1, 'h1, 0, 1, 'h2, 0, 2'b00, 0, 0, 0, 0, 1, 'h1, 'h2};
    tv[1] = '{0, 0, 5, 1, 'h2, 0, 2'b01, 5, 'h55, 0, 0, 1, 'h55, 'h2};
    tv[2] = '{0, 0, 5, 1, 'h2, 0, 2'b11, 5, 'h55, 5, 'h66, 1, 'h55, 'h2};
    tv[3] = '{0, 0, 5, 1, 'h2, 0, 2'b10, 5, 'h77, 5, 'h66, 1, 'h66, 'h2};
    tv[4] = '{1, 'h5, 0, 0, 0, 12, 2'b11, 13, 'h9, 12, 'h1234, 1, 'h5, 'h1234};
    tv[5] = '{0, 0, 5, 1, 'h2, 0, 2'b11, 6, 'h1, 4, 'h2, 0, 0, 0};
    tv[6] = '{0, 0, 7, 0, 0, 7, 2'b01, 7, 'hAB, 0, 0, 1, 'hAB, 'hAB};
    tv[7] = '{1, 'h99, 4, 1, 'h3, 0, 2'b01, 4, 'hEE, 0, 0, 1, 'h99, 'h3};

    // Reset values while rst is held.
    repeat (2) @(negedge clk);
    chk("rst_count", 128'(count), 128'(0));
    chk("rst_alloc_ready", 128'(alloc_ready), 128'(1));
    chk("rst_issue_valid", 128'(issue_valid), 128'(0));
    chk("rst_outputs", {issue_payload, issue_rs1_data}, '0);
    rst = 1'b0;
    @(negedge clk);

    // Both operands ready at allocation: issue the next cycle.
    issue_ready = 1'b1;
    alloc_in(3, 1, 'h10, 0, 1, 'h20, 0); cyc(); idle();
    chk("s1_valid", 128'(issue_valid), 128'(1));
    chk("s1_rs1", 128'(issue_rs1_data), 128'('h10));
    chk("s1_rs2", 128'(issue_rs2_data), 128'('h20));
    chk("s1_rd", 128'(issue_rd_rob_idx), 128'(3));
    cyc();
    chk("s1_count", 128'(count), 128'(0));

    // Both operands captured from two channels in the allocation cycle.
    alloc_in(5, 0, 0, 7, 0, 0, 9); set_cdb(2'b11, 7, 'hAA, 9, 'hBB); cyc(); idle();
    chk("s2_valid", 128'(issue_valid), 128'(1));
    chk("s2_rs1", 128'(issue_rs1_data), 128'('hAA));
    chk("s2_rs2", 128'(issue_rs2_data), 128'('hBB));
    cyc();

    // Fill, then drain in allocation order.
    issue_ready = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      alloc_in(t, 1, t * 16, 0, 1, t, 0); cyc();
    end
    idle();
    chk("s3_full_ready", 128'(alloc_ready), 128'(0));
    chk("s3_full_count", 128'(count), 128'(4));
    issue_ready = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      chk("s3_order", 128'(issue_rd_rob_idx), 128'(t));
      cyc();
      if (t == 1) chk("s3_ready_after_fire", 128'(alloc_ready), 128'(1));
    end

    // Age ordering across slot reuse: A (tag 6) ends up in a higher slot than
    // the younger B (tag 7) but must still go first once woken.
    issue_ready = 1'b0;
    alloc_in(1, 1, 1, 0, 1, 1, 0); cyc();
    alloc_in(6, 0, 0, 20, 1, 2, 0); cyc();
    idle(); issue_ready = 1'b1; cyc();
    issue_ready = 1'b0;
    alloc_in(7, 1, 3, 0, 1, 4, 0); cyc();
    alloc_in(8, 0, 0, 21, 1, 5, 0); cyc();
    idle();
    chk("s4_young_first", 128'(issue_rd_rob_idx), 128'(7));
    set_cdb(2'b11, 20, 'h20, 21, 'h21); cyc(); idle();
    chk("s4_older_takes_over", 128'(issue_rd_rob_idx), 128'(6));
    issue_ready = 1'b1;
    chk("s4_a", 128'(issue_rd_rob_idx), 128'(6)); cyc();
    chk("s4_b", 128'(issue_rd_rob_idx), 128'(7)); cyc();
    chk("s4_c", 128'(issue_rd_rob_idx), 128'(8)); cyc();

    // Flush beats a simultaneous allocation.
    issue_ready = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      alloc_in(10 + t, 1, t, 0, 1, t, 0); cyc();
    end
    alloc_in(15, 1, 1, 0, 1, 1, 0); flush = 1'b1; cyc();
    flush = 1'b0; idle();
    chk("s5_flush_count", 128'(count), 128'(0));
    chk("s5_flush_valid", 128'(issue_valid), 128'(0));

    // Asynchronous reset in the middle of a cycle.
    alloc_in(1, 1, 'h11, 0, 1, 'h22, 0); cyc();
    alloc_in(2, 1, 'h33, 0, 1, 'h44, 0); cyc(); idle();
    chk("s6_pre_count", 128'(count), 128'(2));
    rst = 1'b1;
    #2;
    chk("s6_async_count", 128'(count), 128'(0));
    chk("s6_async_ready", 128'(alloc_ready), 128'(1));
    chk("s6_async_valid", 128'(issue_valid), 128'(0));
    chk("s6_async_data", 128'(issue_rs1_data), 128'(0));
    q.delete();
    rst = 1'b0;
    @(negedge clk);

    // Vector table: single allocation plus CDB activity, checked next cycle.
    issue_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      alloc_in(20 + i, tv[i].r1, tv[i].d1, tv[i].t1, tv[i].r2, tv[i].d2, tv[i].t2);
      set_cdb(tv[i].cv, tv[i].ct0, tv[i].cd0, tv[i].ct1, tv[i].cd1);
      cyc(); idle();
      chk("tv_valid", 128'(issue_valid), 128'(tv[i].ev));
      chk("tv_rs1", 128'(issue_rs1_data), 128'(DW'(tv[i].e1)));
      chk("tv_rs2", 128'(issue_rs2_data), 128'(DW'(tv[i].e2)));
      if (tv[i].ev == 0) flush = 1'b1;
      cyc();
      flush = 1'b0;
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      flush = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 9) < 6)
        alloc_in($urandom_range(0, 31), $urandom_range(0, 1), $urandom, $urandom_range(0, 7),
                 $urandom_range(0, 1), $urandom, $urandom_range(0, 7));
      else
        alloc_valid = 1'b0;
      set_cdb(2'($urandom_range(0, 3)), $urandom_range(0, 7), $urandom,
              $urandom_range(0, 7), $urandom);
      issue_ready = ($urandom_range(0, 9) < 7);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
